// File: rtl/normaliza_arredonda_if.sv
// Handshake and data bundle between the big-ALU stage and the
// normalise/round stage. Signal names match the original port list.
interface normaliza_arredonda_if;
    logic        start;
    logic        sinal_in;
    logic [7:0]  expoente_in;
    logic [27:0] mantissa_in;
    logic [31:0] resultado;
    logic        pronto;
    logic        ocupado;
    logic        overflow;
    logic        underflow;

    // Producer side: issues operands and observes the packed result.
    modport master (
        output start, sinal_in, expoente_in, mantissa_in,
        input  resultado, pronto, ocupado, overflow, underflow
    );

    // Normalise/round unit side.
    modport slave (
        input  start, sinal_in, expoente_in, mantissa_in,
        output resultado, pronto, ocupado, overflow, underflow
    );
endinterface

// File: rtl/normaliza_arredonda.sv
// Normalises a 28-bit big-ALU sum one bit per cycle, rounds it to nearest
// even and packs an IEEE-754 single. No denormals: underflow flushes to zero.
// Mantissa layout: [27] carry, [26] hidden, [25:3] fraction, [2:0] G/R/S.
module normaliza_arredonda (
    input  logic                          clk,
    input  logic                          reset,
    normaliza_arredonda_if.slave          bus
);

    typedef enum logic [2:0] {
        OCIOSO,
        NORMALIZA,
        ARREDONDA,
        VERIFICA,
        FIM
    } estado_t;

    estado_t     estado_q,    estado_d;
    logic        sinal_q,     sinal_d;
    logic [8:0]  expoente_q,  expoente_d;
    logic [27:0] mantissa_q,  mantissa_d;
    logic [31:0] resultado_q, resultado_d;
    logic        overflow_q,  overflow_d;
    logic        underflow_q, underflow_d;

    // Exponent is 9 bits so the 255 check after an increment never wraps.
    logic [8:0]  expoente_inc;
    logic        incrementa;

    assign expoente_inc = expoente_q + 9'd1;
    // Round-to-nearest-even: above half, or exactly half with odd LSB.
    assign incrementa   = mantissa_q[2] & (mantissa_q[1] | mantissa_q[0] | mantissa_q[3]);

    // State and datapath registers; reset clears everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q    <= OCIOSO;
            sinal_q     <= 1'b0;
            expoente_q  <= '0;
            mantissa_q  <= '0;
            resultado_q <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            sinal_q     <= sinal_d;
            expoente_q  <= expoente_d;
            mantissa_q  <= mantissa_d;
            resultado_q <= resultado_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Next-state and datapath: one normalisation step per NORMALIZA cycle.
    always_comb begin
        estado_d    = estado_q;
        sinal_d     = sinal_q;
        expoente_d  = expoente_q;
        mantissa_d  = mantissa_q;
        resultado_d = resultado_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        case (estado_q)
            OCIOSO: begin
                if (bus.start) begin
                    sinal_d     = bus.sinal_in;
                    expoente_d  = {1'b0, bus.expoente_in};
                    mantissa_d  = bus.mantissa_in;
                    overflow_d  = 1'b0;
                    underflow_d = 1'b0;
                    estado_d    = NORMALIZA;
                end
            end

            NORMALIZA: begin
                if (mantissa_q == '0) begin
                    resultado_d = {sinal_q, 31'd0};
                    estado_d    = FIM;
                end else if (mantissa_q[27]) begin
                    // Right shift keeps the dropped bit in the sticky position.
                    mantissa_d = {1'b0, mantissa_q[27:2], mantissa_q[1] | mantissa_q[0]};
                    if (expoente_inc >= 9'd255) begin
                        overflow_d  = 1'b1;
                        resultado_d = {sinal_q, 8'hFF, 23'd0};
                        estado_d    = FIM;
                    end else begin
                        expoente_d = expoente_inc;
                    end
                end else if (!mantissa_q[26]) begin
                    if (expoente_q <= 9'd1) begin
                        underflow_d = 1'b1;
                        resultado_d = {sinal_q, 31'd0};
                        estado_d    = FIM;
                    end else begin
                        mantissa_d = {mantissa_q[26:0], 1'b0};
                        expoente_d = expoente_q - 9'd1;
                    end
                end else begin
                    estado_d = ARREDONDA;
                end
            end

            ARREDONDA: begin
                mantissa_d = mantissa_q + {24'd0, incrementa, 3'b000};
                estado_d   = VERIFICA;
            end

            VERIFICA: begin
                // A rounding carry into [27] renormalises by one; the fraction
                // is then taken one bit higher instead of shifting first.
                if (mantissa_q[27]) begin
                    expoente_d = expoente_inc;
                    if (expoente_inc >= 9'd255) begin
                        overflow_d  = 1'b1;
                        resultado_d = {sinal_q, 8'hFF, 23'd0};
                    end else begin
                        resultado_d = {sinal_q, expoente_inc[7:0], mantissa_q[26:4]};
                    end
                end else begin
                    resultado_d = {sinal_q, expoente_q[7:0], mantissa_q[25:3]};
                end
                estado_d = FIM;
            end

            FIM: begin
                estado_d = OCIOSO;
            end

            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    assign bus.resultado = resultado_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
    assign bus.pronto    = (estado_q == FIM);
    assign bus.ocupado   = (estado_q != OCIOSO);

endmodule

// File: tb/tb_normaliza_arredonda.sv
// Self-checking bench for normaliza_arredonda: directed vector table,
// hand-written reset/start corner sequences and randomized operands
// checked against an arithmetic reference model.
module tb_normaliza_arredonda;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    normaliza_arredonda_if bus_if ();

    normaliza_arredonda dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        s;
        logic [7:0]  e;
        logic [27:0] m;
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Reference: locate the leading one, normalise in one step, round by
    // comparing the discarded three bits against one half.
    function automatic void model(input logic s, input int e, input logic [27:0] m,
                                  output logic [31:0] res, output logic ovf,
                                  output logic unf, output int lat);
        int          p;
        int          sh;
        int          ee;
        int          k;
        logic [31:0] mm;
        logic [31:0] sig;
        logic [31:0] rem;
        ovf = 1'b0;
        unf = 1'b0;
        ee  = e;
        mm  = {4'd0, m};
        if (m == 0) begin
            res = {s, 31'd0};
            lat = 2;
            return;
        end
        p = 0;
        for (int i = 0; i < 28; i++) if (m[i]) p = i;
        if (p == 27) begin
            mm = (mm >> 1) | (mm & 32'd1);
            ee = ee + 1;
            if (ee >= 255) begin
                ovf = 1'b1;
                res = {s, 8'hFF, 23'd0};
                lat = 2;
                return;
            end
            k = 2;
        end else if (p < 26) begin
            sh = 26 - p;
            if (ee <= sh) begin
                unf = 1'b1;
                res = {s, 31'd0};
                lat = ee + 1;
                return;
            end
            mm = mm << sh;
            ee = ee - sh;
            k  = sh + 1;
        end else begin
            k = 1;
        end
        sig = mm >> 3;
        rem = mm & 32'd7;
        if (rem > 4 || (rem == 4 && sig[0])) sig = sig + 1;
        if (sig >= 32'h0100_0000) begin
            sig = sig >> 1;
            ee  = ee + 1;
        end
        if (ee >= 255) begin
            ovf = 1'b1;
            res = {s, 8'hFF, 23'd0};
        end else begin
            res = {s, ee[7:0], sig[22:0]};
        end
        lat = k + 3;
    endfunction

    // Issues one operation (caller is just after a clock edge) and waits for
    // pronto. 'poke' > 0 raises a bogus start at that cycle count.
    task automatic run_op(input logic s, input logic [7:0] e, input logic [27:0] m,
                          input int poke, input string name,
                          output logic [31:0] res, output logic ovf,
                          output logic unf, output int lat);
        int cnt;
        bus_if.start       = 1'b1;
        bus_if.sinal_in    = s;
        bus_if.expoente_in = e;
        bus_if.mantissa_in = m;
        @(posedge clk);
        #1;
        bus_if.start       = 1'b0;
        bus_if.mantissa_in = 28'h4000000;
        bus_if.expoente_in = 8'd200;
        bus_if.sinal_in    = ~s;
        cnt = 1;
        check({name, " ocupado"}, {31'd0, bus_if.ocupado}, 32'd1);
        while (!bus_if.pronto && cnt < 100) begin
            bus_if.start = (cnt == poke);
            @(posedge clk);
            #1;
            cnt++;
        end
        bus_if.start = 1'b0;
        if (!bus_if.pronto) begin
            errors++;
            checks++;
            $display("FAIL %s timeout: got no pronto expected pronto within 100 cycles", name);
        end
        res = bus_if.resultado;
        ovf = bus_if.overflow;
        unf = bus_if.underflow;
        lat = cnt;
        // pronto lasts one cycle, result and flags hold afterwards
        @(posedge clk);
        #1;
        check({name, " pronto_pulse"}, {31'd0, bus_if.pronto}, 32'd0);
        check({name, " hold"}, bus_if.resultado, res);
        check({name, " idle"}, {31'd0, bus_if.ocupado}, 32'd0);
    endtask

    vec_t        tbl[11];
    logic [31:0] r;
    logic        ov, un;
    int          lt;
    logic [31:0] mr;
    logic        mo, mu;
    int          ml;

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        bus_if.start       = 1'b0;
        bus_if.sinal_in    = 1'b0;
        bus_if.expoente_in = 8'd0;
        bus_if.mantissa_in = 28'd0;

        tbl[0]  = '{1'b0, 8'd127, 28'h8000000, 32'h40000000, 1'b0, 1'b0, 5};
        tbl[1]  = '{1'b1, 8'd127, 28'h4000000, 32'hBF800000, 1'b0, 1'b0, 4};
        tbl[2]  = '{1'b0, 8'd127, 28'h4000004, 32'h3F800000, 1'b0, 1'b0, 4};
        tbl[3]  = '{1'b0, 8'd127, 28'h0000008, 32'h34000000, 1'b0, 1'b0, 27};
        tbl[4]  = '{1'b0, 8'd10,  28'h0000008, 32'h00000000, 1'b0, 1'b1, 11};
        tbl[5]  = '{1'b0, 8'd127, 28'h7FFFFFC, 32'h40000000, 1'b0, 1'b0, 4};
        tbl[6]  = '{1'b0, 8'd254, 28'h8000000, 32'h7F800000, 1'b1, 1'b0, 2};
        tbl[7]  = '{1'b1, 8'd127, 28'h0000000, 32'h80000000, 1'b0, 1'b0, 2};
        tbl[8]  = '{1'b0, 8'd127, 28'h4000006, 32'h3F800001, 1'b0, 1'b0, 4};
        tbl[9]  = '{1'b0, 8'd127, 28'h400000C, 32'h3F800002, 1'b0, 1'b0, 4};
        tbl[10] = '{1'b1, 8'd254, 28'h7FFFFFC, 32'hFF800000, 1'b1, 1'b0, 4};

        repeat (2) @(posedge clk);
        #1;
        check("reset resultado", bus_if.resultado, 32'd0);
        check("reset pronto",    {31'd0, bus_if.pronto},    32'd0);
        check("reset ocupado",   {31'd0, bus_if.ocupado},   32'd0);
        check("reset overflow",  {31'd0, bus_if.overflow},  32'd0);
        check("reset underflow", {31'd0, bus_if.underflow}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            run_op(tbl[i].s, tbl[i].e, tbl[i].m, 0, $sformatf("vec%0d", i), r, ov, un, lt);
            check($sformatf("vec%0d resultado", i), r, tbl[i].res);
            check($sformatf("vec%0d overflow", i),  {31'd0, ov}, {31'd0, tbl[i].ovf});
            check($sformatf("vec%0d underflow", i), {31'd0, un}, {31'd0, tbl[i].unf});
            check($sformatf("vec%0d latency", i),   lt, tbl[i].lat);
        end

        // start while busy must not disturb a long cancellation
        run_op(1'b0, 8'd127, 28'h0000008, 5, "busy_start", r, ov, un, lt);
        check("busy_start resultado", r, 32'h34000000);
        check("busy_start latency", lt, 27);

        // start held in the FIM cycle is ignored
        bus_if.start       = 1'b1;
        bus_if.sinal_in    = 1'b0;
        bus_if.expoente_in = 8'd254;
        bus_if.mantissa_in = 28'h8000000;
        while (!bus_if.pronto) begin
            @(posedge clk);
            #1;
            if (bus_if.ocupado && !bus_if.pronto) bus_if.start = 1'b0;
        end
        bus_if.start = 1'b1;
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        check("fim_start ignored", {31'd0, bus_if.ocupado}, 32'd0);
        check("fim_start resultado", bus_if.resultado, 32'h7F800000);
        check("fim_start overflow", {31'd0, bus_if.overflow}, 32'd1);

        // reset 3 cycles into a cancellation aborts it with no pronto
        bus_if.start       = 1'b1;
        bus_if.sinal_in    = 1'b0;
        bus_if.expoente_in = 8'd127;
        bus_if.mantissa_in = 28'h0000008;
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort resultado", bus_if.resultado, 32'd0);
        check("abort ocupado",   {31'd0, bus_if.ocupado},  32'd0);
        check("abort overflow",  {31'd0, bus_if.overflow}, 32'd0);
        check("abort pronto",    {31'd0, bus_if.pronto},   32'd0);
        begin
            int seen;
            seen = 0;
            for (int c = 0; c < 30; c++) begin
                @(posedge clk);
                #1;
                if (bus_if.pronto) seen++;
            end
            check("abort no_pronto", seen, 0);
        end

        // reset with start: reset wins; a fresh start right after is accepted
        bus_if.start = 1'b1;
        bus_if.mantissa_in = 28'h0000008;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("reset_priority ocupado", {31'd0, bus_if.ocupado}, 32'd0);
        reset = 1'b0;
        run_op(1'b1, 8'd127, 28'h4000000, 0, "after_reset", r, ov, un, lt);
        check("after_reset resultado", r, 32'hBF800000);
        check("after_reset latency", lt, 4);

        // randomized operands against the reference model
        for (int n = 0; n < 200; n++) begin
            logic        s;
            logic [7:0]  e;
            logic [27:0] m;
            int          pos;
            s   = 1'($urandom);
            pos = $urandom_range(0, 28);
            if (pos == 28) m = 28'd0;
            else m = (28'($urandom) & ((28'd1 << pos) - 28'd1)) | (28'd1 << pos);
            if ($urandom_range(0, 3) == 0) e = 8'($urandom_range(1, 30));
            else if ($urandom_range(0, 7) == 0) e = 8'($urandom_range(250, 254));
            else e = 8'($urandom_range(1, 254));
            model(s, int'(e), m, mr, mo, mu, ml);
            run_op(s, e, m, 0, $sformatf("rnd%0d", n), r, ov, un, lt);
            check($sformatf("rnd%0d resultado m=%h e=%0d", n, m, e), r, mr);
            check($sformatf("rnd%0d overflow", n),  {31'd0, ov}, {31'd0, mo});
            check($sformatf("rnd%0d underflow", n), {31'd0, un}, {31'd0, mu});
            check($sformatf("rnd%0d latency", n),   lt, ml);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
